// File: rtl/router_sync_param.sv
// Input-buffered mesh router: one FIFO per input, table-driven routing, and a
// registered output stage with a round-robin arbiter per output.
module router_sync_param #(
    parameter int          WIDTH         = 12,
    parameter int          NUM_PORTS     = 4,
    parameter int          FIFO_DEPTH    = 4,
    parameter logic [2:0]  SOURCE_ROUTER = 3'd0,
    parameter logic [23:0] ROUTE_MAP     = 24'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_PORTS*WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]       in_valid,
    output logic [NUM_PORTS-1:0]       in_ready,
    output logic [NUM_PORTS*WIDTH-1:0] out_data,
    output logic [NUM_PORTS-1:0]       out_valid,
    input  logic [NUM_PORTS-1:0]       out_ready,
    output logic [7:0]                 drop_count
);

    // Handshake: a flit moves across an interface on a rising edge where both
    // valid and ready are high; a producer holding valid keeps its data stable.
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [NUM_PORTS][FIFO_DEPTH];
    logic [AW-1:0]    rd_ptr [NUM_PORTS];
    logic [AW-1:0]    wr_ptr [NUM_PORTS];
    logic [AW:0]      count  [NUM_PORTS];
    logic             ready_en;

    logic [WIDTH-1:0] head_data [NUM_PORTS];
    logic [2:0]       head_tgt  [NUM_PORTS];
    logic [NUM_PORTS-1:0] head_valid, drop, push, pop, granted_in;

    logic [NUM_PORTS-1:0] out_free, grant_any;
    logic [PW-1:0]        grant_idx [NUM_PORTS];
    logic [PW-1:0]        rr_ptr    [NUM_PORTS];

    logic [3:0] drop_total;
    logic [8:0] drop_sum;
    logic [7:0] drop_next;

    // ready_en keeps in_ready low during reset and until the first edge after it.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            in_ready[p] = ready_en && (count[p] != FULL_COUNT);
        end
    end

    assign push = in_valid & in_ready;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            head_data[p]  = mem[p][rd_ptr[p]];
            head_valid[p] = (count[p] != '0);
            if (head_data[p][3:1] == SOURCE_ROUTER) begin
                head_tgt[p] = 3'd0;
            end else begin
                head_tgt[p] = ROUTE_MAP[3*int'(head_data[p][3:1]) +: 3];
            end
            drop[p] = head_valid[p] &&
                      ((int'(head_tgt[p]) == p) || (int'(head_tgt[p]) >= NUM_PORTS));
        end
    end

    // Each input has one head and one target, so no input can win two outputs.
    always_comb begin
        int idx;
        idx        = 0;
        granted_in = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            grant_any[o] = 1'b0;
            grant_idx[o] = '0;
            out_free[o]  = !out_valid[o] || out_ready[o];
            if (out_free[o]) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    idx = int'(rr_ptr[o]) + k;
                    if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
                    if (!grant_any[o] && head_valid[idx] && !drop[idx] &&
                        (int'(head_tgt[idx]) == o)) begin
                        grant_any[o]    = 1'b1;
                        grant_idx[o]    = PW'(idx);
                        granted_in[idx] = 1'b1;
                    end
                end
            end
        end
    end

    assign pop = drop | granted_in;

    always_comb begin
        drop_total = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            drop_total = drop_total + {3'b000, drop[p]};
        end
        drop_sum  = {1'b0, drop_count} + {5'b00000, drop_total};
        drop_next = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (push[p]) mem[p][wr_ptr[p]] <= in_data[p*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en   <= 1'b0;
            out_valid  <= '0;
            out_data   <= '0;
            drop_count <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                rd_ptr[p] <= '0;
                wr_ptr[p] <= '0;
                count[p]  <= '0;
                rr_ptr[p] <= '0;
            end
        end else begin
            ready_en   <= 1'b1;
            drop_count <= drop_next;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
                count[p] <= count[p] + {{AW{1'b0}}, push[p]} - {{AW{1'b0}}, pop[p]};
            end
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (grant_any[o]) begin
                    out_data[o*WIDTH +: WIDTH] <= head_data[grant_idx[o]];
                    out_valid[o]               <= 1'b1;
                    if (int'(grant_idx[o]) == NUM_PORTS - 1) begin
                        rr_ptr[o] <= '0;
                    end else begin
                        rr_ptr[o] <= grant_idx[o] + 1'b1;
                    end
                end else if (out_free[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_sync_param.sv
// Bench for router_sync_param: directed scenarios plus random traffic scored
// against a per-(source, output) flit queue model.
module tb_router_sync_param;

    localparam int W = 12;
    localparam int N = 4;
    localparam int D = 4;
    localparam logic [2:0]  SRC = 3'd0;
    localparam logic [23:0] MAP = {3'd3, 3'd0, 3'd5, 3'd1, 3'd2, 3'd3, 3'd1, 3'd0};

    int route_tab [8] = '{0, 1, 3, 2, 1, 5, 0, 3};

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready = '0;
    logic [7:0]     drop_count;

    int total = 0;
    int bad = 0;
    int exp_drops = 0;
    logic [W-1:0] exp_q [N*N][$];
    logic [W-1:0] dir_q [$];
    logic [N-1:0] prev_stall;
    logic [W-1:0] prev_data [N];

    router_sync_param #(
        .WIDTH(W), .NUM_PORTS(N), .FIFO_DEPTH(D),
        .SOURCE_ROUTER(SRC), .ROUTE_MAP(MAP)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid  = '0;
        in_data   = '0;
        out_ready = '0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_drop_count", 32'(drop_count), 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'hF);
    endtask

    function automatic int target_of(input logic [2:0] dest);
        if (dest == SRC) return 0;
        return route_tab[dest];
    endfunction

    task automatic model_push(input int p, input logic [W-1:0] f);
        int t;
        t = target_of(f[3:1]);
        if (t == p || t >= N) exp_drops++;
        else exp_q[p*N + t].push_back(f);
    endtask

    task automatic model_pop(input int o, input logic [W-1:0] f);
        int s, sz;
        s  = int'(f[5:4]);
        sz = exp_q[s*N + o].size();
        check("sb_flit_expected", 32'(sz != 0), 1);
        if (sz != 0) check("sb_out_data", 32'(f), 32'(exp_q[s*N + o].pop_front()));
    endtask

    // Called between edges once the inputs for the coming edge are applied.
    task automatic observe();
        for (int p = 0; p < N; p++) begin
            if (in_valid[p] && in_ready[p]) model_push(p, in_data[p*W +: W]);
        end
        for (int o = 0; o < N; o++) begin
            if (prev_stall[o]) begin
                check("hold_valid", 32'(out_valid[o]), 1);
                check("hold_data", 32'(out_data[o*W +: W]), 32'(prev_data[o]));
            end
            if (out_valid[o] && out_ready[o]) model_pop(o, out_data[o*W +: W]);
            prev_stall[o] = out_valid[o] && !out_ready[o];
            prev_data[o]  = out_data[o*W +: W];
        end
    endtask

    task automatic send_drops(input int n);
        int sent, spur;
        sent = 0;
        spur = 0;
        for (int c = 0; c < 2*n + 20 && sent < n; c++) begin
            in_valid = 4'b0100;
            in_data[2*W +: W] = {8'($urandom), 4'b0110};
            if (in_ready[2]) sent++;
            if (out_valid != '0) spur++;
            step();
        end
        in_valid = '0;
        repeat (3) begin
            if (out_valid != '0) spur++;
            step();
        end
        check("drop_sent", 32'(sent), 32'(n));
        check("drop_no_output", 32'(spur), 0);
    endtask

    initial begin
        logic [W-1:0] ord [3];
        logic [W-1:0] f, held;
        int accepted, got, seen, spur;

        // Uncontended route: port 1, dest 2 -> output 3 after two edges.
        do_reset();
        out_ready = '1;
        in_valid = 4'b0010;
        in_data[W +: W] = 12'h0A4;
        step();
        in_valid = '0;
        check("lat_edge1_valid", 32'(out_valid), 0);
        step();
        check("lat_edge2_valid", 32'(out_valid), 32'h8);
        check("lat_edge2_data", 32'(out_data[3*W +: W]), 32'h0A4);
        check("lat_drop_count", 32'(drop_count), 0);

        // Contention at output 0: order 1, 2, 3 from rr_ptr 0.
        do_reset();
        out_ready = '1;
        ord = '{12'h110, 12'h220, 12'h330};
        in_valid = 4'b1110;
        in_data[1*W +: W] = ord[0];
        in_data[2*W +: W] = ord[1];
        in_data[3*W +: W] = ord[2];
        step();
        in_valid = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rr_valid", 32'(out_valid[0]), 1);
            check("rr_data", 32'(out_data[0 +: W]), 32'(ord[k]));
        end
        step();
        check("rr_idle", 32'(out_valid[0]), 0);

        // Backpressure on output 3 while port 1 streams.
        do_reset();
        out_ready = 4'b0111;
        accepted = 0;
        seen = 0;
        held = '0;
        dir_q.delete();
        for (int c = 0; c < 10; c++) begin
            f = {8'(accepted + 1), 4'h4};
            in_valid = 4'b0010;
            in_data[W +: W] = f;
            if (in_ready[1]) begin
                dir_q.push_back(f);
                accepted++;
            end
            if (seen != 0) begin
                check("bp_hold_valid", 32'(out_valid[3]), 1);
                check("bp_hold_data", 32'(out_data[3*W +: W]), 32'(held));
            end else if (out_valid[3]) begin
                seen = 1;
                held = out_data[3*W +: W];
                check("bp_first_data", 32'(held), 32'h014);
            end
            step();
        end
        in_valid = '0;
        check("bp_in_ready_low", 32'(in_ready[1]), 0);
        check("bp_accepted", 32'(accepted), 32'(D + 1));
        out_ready = '1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid[3]) begin
                got++;
                if (dir_q.size() != 0) check("bp_drain_data", 32'(out_data[3*W +: W]), 32'(dir_q.pop_front()));
            end
            step();
        end
        check("bp_drain_count", 32'(got), 32'(D + 1));

        // U-turn drops from port 2 until drop_count saturates.
        do_reset();
        out_ready = '1;
        send_drops(254);
        check("drop_count_254", 32'(drop_count), 254);
        send_drops(46);
        check("drop_count_sat", 32'(drop_count), 255);

        // Asynchronous reset with three flits buffered.
        do_reset();
        out_ready = '0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 4'b0010;
            in_data[W +: W] = {8'(8'h40 + k), 4'h4};
            step();
        end
        in_valid = '0;
        step();
        check("pre_rst_valid", 32'(out_valid[3]), 1);
        #2 reset = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_in_ready", 32'(in_ready), 0);
        check("arst_drop_count", 32'(drop_count), 0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = '1;
        spur = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (out_valid != '0) spur++;
        end
        check("arst_no_stale", 32'(spur), 0);
        check("arst_in_ready_back", 32'(in_ready), 32'hF);
        in_valid = 4'b0010;
        in_data[W +: W] = 12'h0A4;
        step();
        in_valid = '0;
        step();
        check("arst_new_valid", 32'(out_valid), 32'h8);
        check("arst_new_data", 32'(out_data[3*W +: W]), 32'h0A4);

        // Random traffic against the queue model.
        do_reset();
        exp_drops  = 0;
        prev_stall = '0;
        for (int i = 0; i < N*N; i++) exp_q[i].delete();
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < N; p++) begin
                in_valid[p] = ($urandom_range(3) == 0);
                f = {6'($urandom), 2'(p), 3'($urandom_range(7)), 1'($urandom_range(1))};
                in_data[p*W +: W] = f;
                out_ready[p] = ($urandom_range(3) != 0);
            end
            observe();
            step();
        end
        in_valid  = '0;
        out_ready = '1;
        for (int c = 0; c < 40; c++) begin
            observe();
            step();
        end
        for (int i = 0; i < N*N; i++) check("sb_left_over", 32'(exp_q[i].size()), 0);
        check("rand_out_idle", 32'(out_valid), 0);
        check("rand_drop_count", 32'(drop_count), 32'((exp_drops > 255) ? 255 : exp_drops));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_sync_param.md
ROUTER_SYNC_PARAM -- requirements
Module: router_sync_param

Interface
- REQ-001 SHALL have parameter WIDTH, default 12: flit width; bit 0 reserved, bits [3:1] destination router ID, bits [WIDTH-1:4] payload.
- REQ-002 SHALL have parameter NUM_PORTS, default 4: port count, legal range 2..8; port 0 is the local (processing-element) port.
- REQ-003 SHALL have parameter FIFO_DEPTH, default 4: flits per input FIFO, power of two, at least 2.
- REQ-004 SHALL have parameter SOURCE_ROUTER, default 3'd0: this router's ID.
- REQ-005 SHALL have parameter ROUTE_MAP, default 24'h0: eight 3-bit entries; entry d (bits [3d+2:3d]) is the output port for destination d when d != SOURCE_ROUTER.
- REQ-006 SHALL have port clk, input, 1 bit: single clock, all state on the rising edge.
- REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
- REQ-008 SHALL have port in_data, input, NUM_PORTS*WIDTH bits: input flits; port p occupies slice [p*WIDTH +: WIDTH].
- REQ-009 SHALL have port in_valid, input, NUM_PORTS bits: per-input flit valid.
- REQ-010 SHALL have port in_ready, output, NUM_PORTS bits: per-input space available.
- REQ-011 SHALL have port out_data, output, NUM_PORTS*WIDTH bits: output flits, same slicing as in_data.
- REQ-012 SHALL have port out_valid, output, NUM_PORTS bits: per-output flit valid.
- REQ-013 SHALL have port out_ready, input, NUM_PORTS bits: per-output downstream accept.
- REQ-014 SHALL have port drop_count, output, 8 bits: saturating count of dropped flits.

Function
- REQ-015 SHALL give each input a FIFO of FIFO_DEPTH entries; in_ready[p] = FIFO p not full, with no same-cycle bypass when full.
- REQ-016 SHALL push in_data slice p on a rising edge where in_valid[p] and in_ready[p] are both high.
- REQ-017 SHALL route each FIFO head to target port t = 0 when dest == SOURCE_ROUTER, else t = ROUTE_MAP entry dest.
- REQ-018 SHALL drop a head flit (pop it, no output) when t == p (U-turn, including local loopback) or t >= NUM_PORTS.
- REQ-019 SHALL increment drop_count once per dropped flit and hold it at 255 once reached; multiple drops in one cycle add their total, saturated at 255.
- REQ-020 SHALL register each output: one holding register per output, driving out_data and out_valid.
- REQ-021 SHALL treat output register o as free when out_valid[o] is low, or when out_valid[o] and out_ready[o] are both high in that cycle.
- REQ-022 SHALL, for each free output, grant exactly one requesting input by round-robin: the search starts at rr_ptr[o] and the pointer moves to (granted index + 1) mod NUM_PORTS; the pointer is unchanged when nothing is granted.
- REQ-023 SHALL, on a grant, load the head flit into the output register, set out_valid[o], and pop FIFO p on the same edge.
- REQ-024 SHALL hold out_data[o] and out_valid[o] stable while out_valid[o] is high and out_ready[o] is low.
- REQ-025 SHALL have a latency of 2 rising edges from the accepting edge to out_valid when uncontended: the edge after acceptance loads the output register.
- REQ-026 SHALL sustain 1 flit per cycle per output with out_ready held high.
- REQ-027 SHALL let different outputs grant different inputs in the same cycle; each input is granted to at most one output per cycle, since it has a single head.
- REQ-028 SHALL perform a drop (REQ-018) and a push on the same FIFO in the same edge correctly, with no flit lost or duplicated.

Reset
- REQ-029 SHALL, while reset is high, immediately clear all FIFO pointers and occupancy, out_valid, and drop_count; clear out_data to 0; and set every rr_ptr to 0.
- REQ-030 SHALL hold in_ready low while reset is asserted; after deassertion, in_ready goes high on the first clock edge.
- REQ-031 SHALL discard in-flight flits when reset is asserted mid-operation; no stale flit appears after release.

Verification
- REQ-032 Uncontended route: SOURCE_ROUTER=0, ROUTE_MAP entry 2 = 3; port 1 sends 12'h0A4 (dest 2) -> out_valid[3] high 2 edges later with out_data 12'h0A4; drop_count stays 0.
- REQ-033 Contention: ports 1, 2, 3 each send dest 0 in the same cycle, rr_ptr[0]=0 -> port 0 outputs in order 1, 2, 3 on consecutive cycles.
- REQ-034 Backpressure: out_ready[3]=0 for 10 cycles while port 1 streams to port 3 -> out_data stays stable; in_ready[1] falls after FIFO_DEPTH+1 flits; no loss after release.
- REQ-035 Drops: port 2 sends 300 flits whose route resolves to port 2 -> no out_valid; drop_count saturates at 255.
- REQ-036 Reset mid-traffic: assert reset while 3 flits are buffered -> out_valid and in_ready go low asynchronously; after release, no output until new input arrives.
